// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: default widths, the
// sequencer state encoding and the named ALU opcodes used by the ALU tests.
package alu_seq_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_e;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_MUL   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1000;
    localparam logic [3:0] OP_SHL   = 4'b1001;
    localparam logic [3:0] OP_SHR   = 4'b1010;
    localparam logic [3:0] OP_PASSA = 4'b1011;
    localparam logic [3:0] OP_PASSB = 4'b1100;
    localparam logic [3:0] OP_INC   = 4'b1101;
    localparam logic [3:0] OP_DEC   = 4'b1110;
    localparam logic [3:0] OP_CAT   = 4'b1111;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with asynchronous active-low reset.
// Writes are dropped when full and reads are ignored when empty; the head
// entry is presented combinationally on o_rdata.
module alu_cmd_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == CNT_W'(0));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array: written at the write pointer on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage in front of the ALU: buffers commands in a FIFO, drives one
// command at a time onto the ALU, waits ALU_LAT cycles and holds the
// captured result until the consumer takes it.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int   DATA_W     = DATA_W_DEF,
    parameter int   OP_W       = OP_W_DEF,
    parameter int   FIFO_DEPTH = 4,
    parameter int   ALU_LAT    = 1,
    parameter logic EN_ASSERT  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [DATA_W-1:0]             cmd_a,
    input  logic [DATA_W-1:0]             cmd_b,
    input  logic [OP_W-1:0]               cmd_op,
    output logic [DATA_W-1:0]             alu_a,
    output logic [DATA_W-1:0]             alu_b,
    output logic [OP_W-1:0]               alu_s,
    output logic                          alu_en,
    input  logic [2*DATA_W-1:0]           alu_y,
    input  logic                          alu_carry,
    input  logic                          alu_zero,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [2*DATA_W-1:0]           rsp_y,
    output logic                          rsp_carry,
    output logic                          rsp_zero,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CMD_W  = 2 * DATA_W + OP_W;
    localparam int WCNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    seq_state_e         r_state;
    seq_state_e         w_next_state;
    logic [WCNT_W-1:0]  r_wait_cnt;
    logic               w_wait_last;

    logic [CMD_W-1:0]   w_cmd_word;
    logic [CMD_W-1:0]   w_fifo_rdata;
    logic [CMD_W-1:0]   w_issue_word;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;

    logic               w_alu_en_nxt;
    logic               w_load_issue;
    logic               w_capture;
    logic               w_rsp_take;

    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_alu_s;
    logic                r_alu_en;
    logic                r_rsp_valid;
    logic [2*DATA_W-1:0] r_rsp_y;
    logic                r_rsp_carry;
    logic                r_rsp_zero;

    assign w_cmd_word = {cmd_op, cmd_a, cmd_b};
    assign w_push     = cmd_valid && !w_fifo_full;
    assign w_pop      = (r_state == ST_ISSUE);

    // When RESP hands over to ISSUE on the same edge an entry is pushed into
    // an empty FIFO, the head is not yet readable, so take the incoming word.
    assign w_issue_word = w_fifo_empty ? w_cmd_word : w_fifo_rdata;
    assign w_wait_last  = (r_wait_cnt == WCNT_W'(ALU_LAT - 1));
    assign w_rsp_take   = r_rsp_valid && rsp_ready;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_cmd_word),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && !r_rsp_valid) begin
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_wait_last) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (w_rsp_take) begin
                    if (!w_fifo_empty || w_push) begin
                        w_next_state = ST_ISSUE;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode: what the registered outputs take on the coming edge.
    always_comb begin
        w_alu_en_nxt = ~EN_ASSERT;
        w_load_issue = 1'b0;
        w_capture    = 1'b0;
        if ((w_next_state == ST_ISSUE) || (w_next_state == ST_WAIT)) begin
            w_alu_en_nxt = EN_ASSERT;
        end else begin
            w_alu_en_nxt = ~EN_ASSERT;
        end
        if ((w_next_state == ST_ISSUE) && (r_state != ST_ISSUE)) begin
            w_load_issue = 1'b1;
        end else begin
            w_load_issue = 1'b0;
        end
        if ((r_state == ST_WAIT) && w_wait_last) begin
            w_capture = 1'b1;
        end else begin
            w_capture = 1'b0;
        end
    end

    // ALU latency counter, running only while in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_WAIT) && !w_wait_last) begin
            r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // ALU drive registers: operands load on entry to ISSUE and then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_s  <= '0;
            r_alu_en <= ~EN_ASSERT;
        end else begin
            r_alu_en <= w_alu_en_nxt;
            if (w_load_issue) begin
                r_alu_s <= w_issue_word[CMD_W-1 -: OP_W];
                r_alu_a <= w_issue_word[2*DATA_W-1 -: DATA_W];
                r_alu_b <= w_issue_word[DATA_W-1:0];
            end
        end
    end

    // Response register: captured at the end of WAIT, held until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_y     <= alu_y;
            r_rsp_carry <= alu_carry;
            r_rsp_zero  <= alu_zero;
        end else if (w_rsp_take) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign cmd_ready = !w_fifo_full;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign alu_en    = r_alu_en;
    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign rsp_carry = r_rsp_carry;
    assign rsp_zero  = r_rsp_zero;
    assign busy      = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule
